// File: rtl/arp_pkg.sv
// Shared ARP constants, requester state encoding and the 7-word payload builder
// used for both outgoing requests and incoming reply layout.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETHER = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_MAC    = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IP     = 8'h04;
    localparam logic [15:0] ARP_OP_REQUEST  = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY    = 16'h0002;

    localparam int          ARP_WORDS    = 7;
    localparam logic [2:0]  ARP_LAST_IDX = 3'(ARP_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        TX,
        WAIT,
        DONE
    } arpState_e;

    function automatic logic [31:0] arpWord(
        input logic [2:0]  idx,
        input logic [15:0] oper,
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        logic [31:0] w;
        case (idx)
            3'd0:    w = {ARP_HTYPE_ETHER, ARP_PTYPE_IPV4};
            3'd1:    w = {ARP_HLEN_MAC, ARP_PLEN_IP, oper};
            3'd2:    w = sha[47:16];
            3'd3:    w = {sha[15:0], spa[31:16]};
            3'd4:    w = {spa[15:0], tha[47:32]};
            3'd5:    w = tha[31:0];
            3'd6:    w = tpa;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/arp_requester_if.sv
// Bundles the request, TX stream, RX stream, result and configuration signals
// of the ARP requester; master is the requester side, slave the environment.
interface arp_requester_if;

    logic        i_req_valid;
    logic [31:0] i_req_ip;
    logic        o_req_ready;

    logic [31:0] o_tx_data;
    logic        o_tx_valid;
    logic        o_tx_last;
    logic        i_tx_ready;

    logic [31:0] i_rx_data;
    logic        i_rx_valid;
    logic        i_rx_last;
    logic        o_rx_ready;

    logic        o_res_valid;
    logic        o_res_hit;
    logic [47:0] o_res_mac;
    logic [31:0] o_res_ip;

    logic [47:0] i_local_mac;
    logic [31:0] i_local_ip;
    logic        i_arp_enable;

    modport master (
        input  i_req_valid, i_req_ip,
        output o_req_ready,
        output o_tx_data, o_tx_valid, o_tx_last,
        input  i_tx_ready,
        input  i_rx_data, i_rx_valid, i_rx_last,
        output o_rx_ready,
        output o_res_valid, o_res_hit, o_res_mac, o_res_ip,
        input  i_local_mac, i_local_ip, i_arp_enable
    );

    modport slave (
        output i_req_valid, i_req_ip,
        input  o_req_ready,
        input  o_tx_data, o_tx_valid, o_tx_last,
        output i_tx_ready,
        output i_rx_data, i_rx_valid, i_rx_last,
        input  o_rx_ready,
        input  o_res_valid, o_res_hit, o_res_mac, o_res_ip,
        output i_local_mac, i_local_ip, i_arp_enable
    );

endinterface

// File: rtl/arp_reply_checker.sv
// Parses the RX ARP payload stream and flags a reply that answers our request;
// only frames that begin while the window is open are ever considered.
module arp_reply_checker
    import arp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    input  logic [31:0] target_ip_i,
    input  logic [31:0] local_ip_i,
    input  logic        window_i,
    output logic        match_o,
    output logic [47:0] sha_o
);

    localparam logic [2:0] OVER_IDX = 3'(ARP_WORDS);

    logic [2:0]  idx_q, idx_d;
    logic        midFrame_q, midFrame_d;
    logic        skip_q, skip_d;
    logic        ok_q, ok_d;
    logic [31:0] shaHi_q, shaHi_d;
    logic [15:0] shaLo_q, shaLo_d;

    logic [2:0]  curIdx;
    logic        parse;
    logic        wordOk;
    logic        frameOk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            midFrame_q <= 1'b0;
            skip_q     <= 1'b1;
            ok_q       <= 1'b0;
            shaHi_q    <= '0;
            shaLo_q    <= '0;
        end else begin
            idx_q      <= idx_d;
            midFrame_q <= midFrame_d;
            skip_q     <= skip_d;
            ok_q       <= ok_d;
            shaHi_q    <= shaHi_d;
            shaLo_q    <= shaLo_d;
        end
    end

    // A frame is parsed only if the window was open on its first beat and has
    // stayed open since; OVER_IDX marks a frame that ran past W6 without last.
    always_comb begin
        curIdx     = midFrame_q ? idx_q : 3'd0;
        parse      = midFrame_q ? (!skip_q && window_i) : window_i;
        idx_d      = idx_q;
        midFrame_d = midFrame_q;
        skip_d     = skip_q || !window_i;
        ok_d       = ok_q;
        shaHi_d    = shaHi_q;
        shaLo_d    = shaLo_q;

        case (curIdx)
            3'd0:    wordOk = (rx_data_i == {ARP_HTYPE_ETHER, ARP_PTYPE_IPV4});
            3'd1:    wordOk = (rx_data_i == {ARP_HLEN_MAC, ARP_PLEN_IP, ARP_OP_REPLY});
            3'd3:    wordOk = (rx_data_i[15:0] == target_ip_i[31:16]);
            3'd4:    wordOk = (rx_data_i[31:16] == target_ip_i[15:0]);
            3'd6:    wordOk = (rx_data_i == local_ip_i);
            3'd7:    wordOk = 1'b0;
            default: wordOk = 1'b1;
        endcase

        frameOk = (midFrame_q ? ok_q : 1'b1) && wordOk;
        match_o = rx_valid_i && rx_last_i && parse && (curIdx == ARP_LAST_IDX) && frameOk;
        sha_o   = {shaHi_q, shaLo_q};

        if (rx_valid_i) begin
            if (rx_last_i) begin
                midFrame_d = 1'b0;
                idx_d      = '0;
                ok_d       = 1'b0;
            end else begin
                midFrame_d = 1'b1;
                idx_d      = (curIdx == OVER_IDX) ? OVER_IDX : curIdx + 3'd1;
                ok_d       = frameOk;
                skip_d     = !parse;
            end
            if (parse && curIdx == 3'd2) begin
                shaHi_d = rx_data_i;
            end
            if (parse && curIdx == 3'd3) begin
                shaLo_d = rx_data_i[31:16];
            end
        end
    end

endmodule

// File: rtl/arp_requester.sv
// ARP requester: sends a who-has request for a target IPv4 address, resends on
// timeout and reports the resolved MAC (or a failure) as a one-cycle result.
module arp_requester
    import arp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    arp_requester_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    arpState_e   state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]  txIdx_q, txIdx_d;
    logic        abort_q, abort_d;
    logic        resHit_q, resHit_d;
    logic [47:0] resMac_q, resMac_d;
    logic [31:0] resIp_q, resIp_d;

    logic        rxMatch;
    logic [47:0] rxSha;
    logic        failNow;

    arp_reply_checker u_checker (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data_i   (bus.i_rx_data),
        .rx_valid_i  (bus.i_rx_valid),
        .rx_last_i   (bus.i_rx_last),
        .target_ip_i (target_q),
        .local_ip_i  (bus.i_local_ip),
        .window_i    (state_q == WAIT),
        .match_o     (rxMatch),
        .sha_o       (rxSha)
    );

    // Ready is gated by rst_n so every output except rx_ready reads 0 during reset.
    assign bus.o_req_ready = rst_n && (state_q == IDLE) && bus.i_arp_enable;
    assign bus.o_tx_valid  = (state_q == TX);
    assign bus.o_tx_last   = (state_q == TX) && (txIdx_q == ARP_LAST_IDX);
    assign bus.o_tx_data   = (state_q == TX)
                           ? arpWord(txIdx_q, ARP_OP_REQUEST, bus.i_local_mac,
                                     bus.i_local_ip, 48'h0, target_q)
                           : 32'h0;
    assign bus.o_rx_ready  = 1'b1;
    assign bus.o_res_valid = (state_q == DONE);
    assign bus.o_res_hit   = resHit_q;
    assign bus.o_res_mac   = resMac_q;
    assign bus.o_res_ip    = resIp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            txIdx_q  <= '0;
            abort_q  <= 1'b0;
            resHit_q <= 1'b0;
            resMac_q <= '0;
            resIp_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            txIdx_q  <= txIdx_d;
            abort_q  <= abort_d;
            resHit_q <= resHit_d;
            resMac_q <= resMac_d;
            resIp_q  <= resIp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        txIdx_d  = txIdx_q;
        abort_d  = abort_q;
        resHit_d = resHit_q;
        resMac_d = resMac_q;
        resIp_d  = resIp_q;
        failNow  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req_valid && bus.o_req_ready) begin
                    target_d = bus.i_req_ip;
                    retry_d  = '0;
                    txIdx_d  = '0;
                    abort_d  = 1'b0;
                    state_d  = TX;
                end
            end

            // A disable seen at any point of a frame is remembered; the frame
            // still completes so the framer never sees a truncated payload.
            TX: begin
                abort_d = abort_q || !bus.i_arp_enable;
                if (bus.i_tx_ready) begin
                    if (txIdx_q == ARP_LAST_IDX) begin
                        txIdx_d = '0;
                        if (abort_d) begin
                            failNow = 1'b1;
                        end else begin
                            timer_d = TIMER_LOAD;
                            state_d = WAIT;
                        end
                    end else begin
                        txIdx_d = txIdx_q + 3'd1;
                    end
                end
            end

            // Priority: a matching reply beats both disable and timer expiry.
            WAIT: begin
                timer_d = timer_q - TW'(1);
                if (rxMatch) begin
                    resHit_d = 1'b1;
                    resMac_d = rxSha;
                    resIp_d  = target_q;
                    state_d  = DONE;
                end else if (!bus.i_arp_enable) begin
                    failNow = 1'b1;
                end else if (timer_q <= TW'(1)) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        txIdx_d = '0;
                        abort_d = 1'b0;
                        state_d = TX;
                    end else begin
                        failNow = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (failNow) begin
            resHit_d = 1'b0;
            resMac_d = '0;
            resIp_d  = target_q;
            state_d  = DONE;
        end
    end

endmodule

// File: tb/tb_arp_requester.sv
// Randomized scoreboard bench for arp_requester: stimulus queues expected TX
// words and results from a packet-level model; negedge monitors pop and compare.
module tb_arp_requester;

    localparam int          TIMEOUT   = 64;
    localparam int          RETRIES   = 2;
    localparam logic [47:0] LOCAL_MAC = 48'h020000000001;
    localparam logic [31:0] LOCAL_IP  = 32'hC0A8010A;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } txExp_t;

    typedef struct {
        logic        hit;
        logic [47:0] mac;
        logic [31:0] ip;
    } resExp_t;

    logic clk = 1'b0;
    logic rst_n;

    arp_requester_if bus ();

    arp_requester #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES    (RETRIES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int      assertCount = 0;
    int      failCount   = 0;
    int      cyc         = 0;
    int      resSeen     = 0;
    int      resCyc      = 0;
    int      expRes      = 0;
    bit      randReady   = 0;
    txExp_t  txExpQ[$];
    resExp_t resExpQ[$];
    int      frameStartQ[$];
    int      frameEndQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Packet-level model: the ARP payload as one big-endian 28-byte field sequence.
    function automatic logic [223:0] arpPacket(input logic [15:0] oper, input logic [47:0] sha,
                                               input logic [31:0] spa, input logic [47:0] tha,
                                               input logic [31:0] tpa);
        return {16'h0001, 16'h0800, 8'd6, 8'd4, oper, sha, spa, tha, tpa};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic pushFrame(input logic [31:0] target);
        logic [223:0] pkt;
        pkt = arpPacket(16'h0001, LOCAL_MAC, LOCAL_IP, 48'h0, target);
        for (int i = 0; i < 7; i++) begin
            txExpQ.push_back('{pkt[223 - 32*i -: 32], (i == 6)});
        end
    endtask

    task automatic pushResult(input logic hit, input logic [47:0] mac, input logic [31:0] ip);
        resExpQ.push_back('{hit, mac, ip});
        expRes++;
    endtask

    task automatic applyStimulus(input logic [31:0] target);
        int n = 0;
        while (!bus.o_req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.o_req_ready) reportTimeout("req_ready wait");
        bus.i_req_valid = 1'b1;
        bus.i_req_ip    = target;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        bus.i_req_ip    = $urandom;
    endtask

    task automatic sendRxFrame(input logic [223:0] pkt, input int nWords);
        for (int i = 0; i < nWords; i++) begin
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = pkt[223 - 32*i -: 32];
            bus.i_rx_last  = (i == nWords - 1);
            @(posedge clk); #1;
        end
        bus.i_rx_valid = 1'b0;
        bus.i_rx_last  = 1'b0;
        bus.i_rx_data  = '0;
    endtask

    task automatic waitTxDrained(input int budget);
        int n = 0;
        while ((txExpQ.size() != 0 || bus.o_tx_valid) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (txExpQ.size() != 0 || bus.o_tx_valid) reportTimeout("tx drain");
    endtask

    task automatic waitResults(input int budget);
        int n = 0;
        while (resSeen < expRes && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (resSeen < expRes) reportTimeout("result wait");
    endtask

    task automatic waitUntilCyc(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ready"}, 64'(bus.o_req_ready), 64'd0);
        checkOutput({tag, " tx_valid"},  64'(bus.o_tx_valid),  64'd0);
        checkOutput({tag, " tx_last"},   64'(bus.o_tx_last),   64'd0);
        checkOutput({tag, " tx_data"},   64'(bus.o_tx_data),   64'd0);
        checkOutput({tag, " rx_ready"},  64'(bus.o_rx_ready),  64'd1);
        checkOutput({tag, " res_valid"}, 64'(bus.o_res_valid), 64'd0);
        checkOutput({tag, " res_hit"},   64'(bus.o_res_hit),   64'd0);
        checkOutput({tag, " res_mac"},   64'(bus.o_res_mac),   64'd0);
        checkOutput({tag, " res_ip"},    64'(bus.o_res_ip),    64'd0);
    endtask

    // TX monitor: pops one expected word per handshake and checks stall stability.
    bit          prevTxValid = 0;
    bit          holdValid   = 0;
    logic [31:0] heldData    = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_tx_valid) begin
                if (!prevTxValid) frameStartQ.push_back(cyc);
                if (holdValid) checkOutput("tx stable while stalled", 64'(bus.o_tx_data), 64'(heldData));
                if (bus.i_tx_ready) begin
                    if (txExpQ.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL tx unexpected word: got 0x%0h, expected no word", bus.o_tx_data);
                    end else begin
                        txExp_t e;
                        e = txExpQ.pop_front();
                        checkOutput("tx data", 64'(bus.o_tx_data), 64'(e.data));
                        checkOutput("tx last", 64'(bus.o_tx_last), 64'(e.last));
                    end
                    if (bus.o_tx_last) frameEndQ.push_back(cyc);
                    holdValid = 0;
                end else begin
                    holdValid = 1;
                    heldData  = bus.o_tx_data;
                end
            end else begin
                holdValid = 0;
            end
            prevTxValid = bus.o_tx_valid;
        end else begin
            holdValid   = 0;
            prevTxValid = 0;
        end
    end

    // Result monitor: every pulse must be expected and last exactly one cycle.
    bit prevResValid = 0;
    always @(negedge clk) begin
        if (rst_n && bus.o_res_valid) begin
            if (prevResValid) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL res pulse width: got valid on consecutive cycles, expected one");
            end
            if (resExpQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL res unexpected: got hit=%0b ip=0x%0h, expected no result",
                         bus.o_res_hit, bus.o_res_ip);
            end else begin
                resExp_t e;
                e = resExpQ.pop_front();
                checkOutput("res hit", 64'(bus.o_res_hit), 64'(e.hit));
                checkOutput("res mac", 64'(bus.o_res_mac), 64'(e.mac));
                checkOutput("res ip",  64'(bus.o_res_ip),  64'(e.ip));
            end
            resSeen++;
            resCyc = cyc;
        end
        prevResValid = rst_n && bus.o_res_valid;
    end

    always begin
        @(posedge clk); #1;
        bus.i_tx_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0]  target;
        logic [47:0]  mac;
        logic [223:0] goodReply;
        int           t;

        rst_n            = 1'b0;
        bus.i_req_valid  = 1'b0;
        bus.i_req_ip     = '0;
        bus.i_rx_data    = '0;
        bus.i_rx_valid   = 1'b0;
        bus.i_rx_last    = 1'b0;
        bus.i_local_mac  = LOCAL_MAC;
        bus.i_local_ip   = LOCAL_IP;
        bus.i_arp_enable = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("req_ready after reset", 64'(bus.o_req_ready), 64'd1);

        $display("[TB] basic request and resolve");
        target    = 32'hC0A80114;
        goodReply = arpPacket(16'h0002, 48'h001122334455, target, LOCAL_MAC, LOCAL_IP);
        pushFrame(target);
        applyStimulus(target);
        waitTxDrained(100);
        pushResult(1'b1, 48'h001122334455, target);
        sendRxFrame(goodReply, 7);
        waitResults(50);

        $display("[TB] timeout with retries");
        frameStartQ.delete();
        frameEndQ.delete();
        repeat (RETRIES + 1) pushFrame(target);
        pushResult(1'b0, 48'h0, target);
        applyStimulus(target);
        waitResults(400);
        checkOutput("timeout frame count", 64'(frameStartQ.size()), 64'(RETRIES + 1));
        if (frameStartQ.size() == 3 && frameEndQ.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                checkOutput("retry gap", 64'(frameStartQ[i] - frameEndQ[i-1]), 64'(TIMEOUT + 1));
            end
            checkOutput("fail result gap", 64'(resCyc - frameEndQ[2]), 64'(TIMEOUT + 1));
        end

        $display("[TB] reply filtering");
        pushFrame(target);
        applyStimulus(target);
        waitTxDrained(100);
        sendRxFrame(arpPacket(16'h0002, 48'h00AABBCCDDEE, 32'hC0A80115, LOCAL_MAC, LOCAL_IP), 7);
        sendRxFrame(arpPacket(16'h0001, 48'h00AABBCCDDEE, target, LOCAL_MAC, LOCAL_IP), 7);
        sendRxFrame(goodReply, 5);
        pushResult(1'b1, 48'h001122334455, target);
        sendRxFrame(goodReply, 7);
        waitResults(50);

        $display("[TB] reply on timer expiry");
        pushFrame(target);
        applyStimulus(target);
        waitTxDrained(100);
        t = frameEndQ[frameEndQ.size() - 1];
        waitUntilCyc(t + TIMEOUT - 6);
        pushResult(1'b1, 48'h001122334455, target);
        sendRxFrame(goodReply, 7);
        waitResults(50);
        checkOutput("race result cycle", 64'(resCyc), 64'(t + TIMEOUT + 1));

        $display("[TB] disable during WAIT");
        pushFrame(target);
        applyStimulus(target);
        waitTxDrained(100);
        repeat (5) @(posedge clk);
        #1;
        pushResult(1'b0, 48'h0, target);
        bus.i_arp_enable = 1'b0;
        t = cyc;
        waitResults(20);
        checkOutput("wait abort latency", 64'(resCyc), 64'(t + 1));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("req_ready while disabled", 64'(bus.o_req_ready), 64'd0);
        bus.i_arp_enable = 1'b1;

        $display("[TB] disable during TX");
        target = 32'h0A000001;
        pushFrame(target);
        pushResult(1'b0, 48'h0, target);
        applyStimulus(target);
        @(posedge clk); #1;
        bus.i_arp_enable = 1'b0;
        waitResults(30);
        checkOutput("tx abort result cycle", 64'(resCyc), 64'(frameEndQ[frameEndQ.size() - 1] + 1));
        bus.i_arp_enable = 1'b1;

        $display("[TB] random targets under TX backpressure");
        randReady = 1;
        for (int k = 0; k < 5; k++) begin
            target = $urandom;
            mac    = {16'($urandom), 32'($urandom)};
            pushFrame(target);
            applyStimulus(target);
            waitTxDrained(300);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            pushResult(1'b1, mac, target);
            sendRxFrame(arpPacket(16'h0002, mac, target, LOCAL_MAC, LOCAL_IP), 7);
            waitResults(50);
        end

        $display("[TB] reset mid-TX");
        target = 32'hC0A80199;
        pushFrame(target);
        applyStimulus(target);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid-tx reset");
        txExpQ.delete();
        randReady = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("req_ready after mid-tx reset", 64'(bus.o_req_ready), 64'd1);

        target = 32'hC0A80114;
        pushFrame(target);
        applyStimulus(target);
        waitTxDrained(100);
        pushResult(1'b1, 48'h001122334455, target);
        sendRxFrame(goodReply, 7);
        waitResults(50);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("tx expectations left", 64'(txExpQ.size()), 64'd0);
        checkOutput("result expectations left", 64'(resExpQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
